// File: rtl/pat_pkg.sv
// Shared types, pattern lengths and pattern tables for the pattern scheduler.
// Tables are packed with element 0 in the LSBs; unused slots read as 0.
package pat_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef logic [1:0] mode_t;

  localparam logic [3:0] LEN_M0 = 4'd12;
  localparam logic [3:0] LEN_M1 = 4'd4;
  localparam logic [3:0] LEN_M2 = 4'd6;
  localparam logic [3:0] LEN_M3 = 4'd2;

  localparam logic [31:0] PAT_M0 = {8'h00, 2'd1, 2'd2, 2'd2, 2'd1, 2'd3, 2'd2,
                                    2'd0, 2'd3, 2'd3, 2'd0, 2'd2, 2'd3};
  localparam logic [31:0] PAT_M1 = {24'h0, 2'd0, 2'd2, 2'd3, 2'd1};
  localparam logic [31:0] PAT_M2 = {20'h0, 2'd0, 2'd3, 2'd2, 2'd2, 2'd1, 2'd2};
  localparam logic [31:0] PAT_M3 = {28'h0, 2'd2, 2'd1};

  function automatic logic [1:0] pat_elem(input mode_t m, input logic [3:0] step);
    logic [31:0] tbl;
    case (m)
      2'd0:    tbl = PAT_M0;
      2'd1:    tbl = PAT_M1;
      2'd2:    tbl = PAT_M2;
      default: tbl = PAT_M3;
    endcase
    return tbl[{step, 1'b0} +: 2];
  endfunction

  function automatic logic [3:0] pat_len(input mode_t m);
    case (m)
      2'd0:    return LEN_M0;
      2'd1:    return LEN_M1;
      2'd2:    return LEN_M2;
      default: return LEN_M3;
    endcase
  endfunction

endpackage

// File: rtl/pattern_rom.sv
// Combinational pattern lookup: (mode, step) -> element, mode -> pattern length.
module pattern_rom
  import pat_pkg::*;
(
  input  mode_t      mode,
  input  logic [3:0] step,
  output logic [1:0] z,
  output logic [3:0] len
);

  assign z   = pat_elem(mode, step);
  assign len = pat_len(mode);

endmodule

// File: rtl/pattern_scheduler.sv
// Round-robin arbiter + sequencer for the shared 2-bit pattern source; grant and first element
// appear one cycle after req is sampled in IDLE. Optional abort port under PATSCHED_ABORT_EN.
module pattern_scheduler
  import pat_pkg::*;
#(
  parameter  int NREQ = 2,
  parameter  int REPW = 4,
  localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    mode,
  input  logic [REPW*NREQ-1:0] reps,
`ifdef PATSCHED_ABORT_EN
  input  logic                 abort,
`endif
  output logic [NREQ-1:0]      gnt,
  output logic [OW-1:0]        owner,
  output logic [1:0]           z,
  output logic                 z_valid,
  output logic                 busy,
  output logic                 done
);

  state_e            state_q, state_d;
  logic [3:0]        step_q, step_d;
  logic [REPW-1:0]   pass_q, pass_d;
  mode_t             mode_q, mode_d;
  logic [REPW-1:0]   reps_q, reps_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [1:0]        z_q, z_d;
  logic              z_valid_q, z_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              found;
  logic [OW-1:0]     win_idx;
  mode_t             win_mode;
  logic [REPW-1:0]   win_reps;
  mode_t             rom_mode;
  logic [3:0]        rom_step;
  logic [1:0]        rom_z;
  logic [3:0]        rom_len;
  logic              last_step;
  logic              abort_hit;

`ifdef PATSCHED_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // First requester at or after the pointer wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int off = 0; off < NREQ; off++) begin
      if (!found && req[(int'(ptr_q) + off) % NREQ]) begin
        found   = 1'b1;
        win_idx = OW'((int'(ptr_q) + off) % NREQ);
      end
    end
  end

  assign win_mode = mode[2*int'(win_idx) +: 2];
  assign win_reps = reps[REPW*int'(win_idx) +: REPW];

  // One ROM serves both the first element of a new grant and the next element of a run.
  assign rom_mode  = (state_q == S_IDLE) ? win_mode : mode_q;
  assign last_step = (step_q == rom_len - 4'd1);
  assign rom_step  = (state_q == S_RUN && !last_step) ? step_q + 4'd1 : 4'd0;

  pattern_rom u_rom (
    .mode (rom_mode),
    .step (rom_step),
    .z    (rom_z),
    .len  (rom_len)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    pass_d    = pass_q;
    mode_d    = mode_q;
    reps_d    = reps_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    gnt_d     = '0;
    z_d       = 2'd0;
    z_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d          = S_RUN;
          mode_d           = win_mode;
          reps_d           = win_reps;
          step_d           = 4'd0;
          pass_d           = '0;
          gnt_d[win_idx]   = 1'b1;
          owner_d          = win_idx;
          ptr_d            = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + OW'(1);
          z_d              = rom_z;
          z_valid_d        = 1'b1;
          busy_d           = 1'b1;
        end
      end
      S_RUN: begin
        if (abort_hit || (last_step && pass_q == reps_q)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          if (last_step) begin
            step_d = 4'd0;
            pass_d = pass_q + REPW'(1);
          end else begin
            step_d = step_q + 4'd1;
          end
          z_d       = rom_z;
          z_valid_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      step_q    <= 4'd0;
      pass_q    <= '0;
      mode_q    <= 2'd0;
      reps_q    <= '0;
      ptr_q     <= '0;
      owner_q   <= '0;
      gnt_q     <= '0;
      z_q       <= 2'd0;
      z_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      pass_q    <= pass_d;
      mode_q    <= mode_d;
      reps_q    <= reps_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      z_q       <= z_d;
      z_valid_q <= z_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign z       = z_q;
  assign z_valid = z_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Directed bench for pattern_scheduler: run vectors from a table, then reset, fairness and abort sequences.
module tb_pattern_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [3:0] mode_in = 4'h0;
  logic [7:0] reps_in = 8'h00;
`ifdef PATSCHED_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic [1:0] gnt;
  logic [0:0] owner;
  logic [1:0] z;
  logic       z_valid, busy, done;

  pattern_scheduler dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .mode    (mode_in),
    .reps    (reps_in),
`ifdef PATSCHED_ABORT_EN
    .abort   (abort),
`endif
    .gnt     (gnt),
    .owner   (owner),
    .z       (z),
    .z_valid (z_valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int tab [4][12];

  typedef struct {
    logic [1:0] req;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [3:0] r0;
    logic [3:0] r1;
    int         exp_owner;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int plen(input int m);
    case (m)
      0:       return 12;
      1:       return 4;
      2:       return 6;
      default: return 2;
    endcase
  endfunction

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL gnt_timeout: got no grant expected a grant at %0t", $time);
    end
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic do_run(input vec_t v);
    int m, r, w, n;
    bit ok;
    @(negedge clk);
    req     = v.req;
    mode_in = {v.m1, v.m0};
    reps_in = {v.r1, v.r0};
    w = v.exp_owner;
    m = (w == 1) ? int'(v.m1) : int'(v.m0);
    r = (w == 1) ? int'(v.r1) : int'(v.r0);
    n = plen(m) * (r + 1);
    wait_gnt(ok);
    if (!ok) return;
    chk("gnt", 32'(gnt), 32'(1 << w));
    chk("owner", 32'(owner), 32'(w));
    // Inputs scrambled mid-run must not disturb the latched run.
    req     = 2'b00;
    mode_in = ~mode_in;
    reps_in = ~reps_in;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(negedge clk);
        chk("gnt_low", 32'(gnt), 32'd0);
      end
      chk("z", 32'(z), 32'(tab[m][i % plen(m)]));
      chk("z_valid", 32'(z_valid), 32'd1);
      chk("busy", 32'(busy), 32'd1);
      chk("done_low", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("done", 32'(done), 32'd1);
    chk("z_valid_off", 32'(z_valid), 32'd0);
    chk("z_zero", 32'(z), 32'd0);
    chk("busy_off", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_gnt", 32'(gnt), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ok;
    int cnt;
    tab[0] = '{3, 2, 0, 3, 3, 0, 2, 3, 1, 2, 2, 1};
    tab[1] = '{1, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tab[2] = '{2, 1, 2, 2, 3, 0, 0, 0, 0, 0, 0, 0};
    tab[3] = '{1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    vecs[0] = '{2'b01, 2'd1, 2'd0, 4'd0,  4'd0, 0};
    vecs[1] = '{2'b10, 2'd0, 2'd3, 4'd0,  4'd2, 1};
    vecs[2] = '{2'b01, 2'd2, 2'd1, 4'd0,  4'd5, 0};
    vecs[3] = '{2'b11, 2'd3, 2'd1, 4'd0,  4'd0, 1};
    vecs[4] = '{2'b11, 2'd3, 2'd1, 4'd1,  4'd0, 0};
    vecs[5] = '{2'b10, 2'd2, 2'd0, 4'd0,  4'd1, 1};
    vecs[6] = '{2'b01, 2'd3, 2'd2, 4'd15, 4'd0, 0};

    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_z", 32'(z), 32'd0);
    chk("rst_z_valid", 32'(z_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 7; k++) do_run(vecs[k]);

    // Reset during step 3 of a mode-2 run, with the pointer advanced past requester 0.
    @(negedge clk);
    req = 2'b01; mode_in = {2'd0, 2'd2}; reps_in = 8'h00;
    wait_gnt(ok);
    chk("d_owner", 32'(owner), 32'd0);
    req = 2'b00;
    repeat (3) @(negedge clk);
    chk("d_step3", 32'(z), 32'(tab[2][3]));
    rst = 1'b1;
    #1;
    chk("d_rst_z", 32'(z), 32'd0);
    chk("d_rst_z_valid", 32'(z_valid), 32'd0);
    chk("d_rst_busy", 32'(busy), 32'd0);
    chk("d_rst_done", 32'(done), 32'd0);
    chk("d_rst_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    rst = 1'b0; req = 2'b11; mode_in = {2'd3, 2'd3}; reps_in = 8'h00;
    wait_gnt(ok);
    chk("d_regrant", 32'(gnt), 32'd1);
    req = 2'b00;
    wait_done("d_done_seen");

    // Both requesters held from reset: grants alternate with a DONE+IDLE gap.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; req = 2'b11; mode_in = {2'd3, 2'd3}; reps_in = 8'h00;
    wait_gnt(ok);
    chk("b_gnt0", 32'(gnt), 32'd1);
    for (int k = 1; k <= 2; k++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (gnt == 2'b00 && cnt < 20);
      chk("b_gap", 32'(cnt), 32'd4);
      chk("b_gnt", 32'(gnt), (k == 1) ? 32'd2 : 32'd1);
    end
    req = 2'b00;
    wait_done("b_done_seen");
    @(negedge clk);

`ifdef PATSCHED_ABORT_EN
    @(negedge clk);
    req = 2'b01; mode_in = {2'd0, 2'd0}; reps_in = 8'h00;
    wait_gnt(ok);
    req = 2'b00;
    repeat (2) @(negedge clk);
    chk("e_step2", 32'(z), 32'(tab[0][2]));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("e_z_valid", 32'(z_valid), 32'd0);
    chk("e_done", 32'(done), 32'd1);
    chk("e_busy", 32'(busy), 32'd0);
    do_run('{2'b10, 2'd0, 2'd1, 4'd0, 4'd0, 1});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
